// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: sync, glitch filter, Gray decode to one-cycle en/dir steps plus sticky err.
// Latency FILT_CYC+3 edges from input change to en; no backpressure, activity faster than FILT_CYC is filtered.
module quad_step_decoder #(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic err_clr,
  output logic en,
  output logic dir,
  output logic err,
  output logic a_f,
  output logic b_f
);

  typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S10 = 2'b10, S11 = 2'b11} state_t;

  localparam logic [3:0] FILT_MAX   = 4'(FILT_CYC - 1);
  localparam logic [4:0] PRIME_LAST = 5'(FILT_CYC + 1);

  logic       a_m, b_m, a_s, b_s;
  logic [3:0] a_cnt, b_cnt;
  logic [4:0] prime_cnt;
  logic       primed;
  state_t     state, state_nxt;
  logic [1:0] cur;
  logic       en_nxt, dir_nxt, err_set;

  function automatic state_t up_of(input state_t s);
    case (s)
      S00:     up_of = S10;
      S10:     up_of = S11;
      S11:     up_of = S01;
      default: up_of = S00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_m <= 1'b0;
      b_m <= 1'b0;
      a_s <= 1'b0;
      b_s <= 1'b0;
    end else begin
      a_m <= a_in;
      b_m <= b_in;
      a_s <= a_m;
      b_s <= b_m;
    end
  end

  // Until primed the filters follow the synchronisers so a resting non-00 position is absorbed silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 5'd1;
      if (prime_cnt == PRIME_LAST) primed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_f   <= 1'b0;
      a_cnt <= '0;
    end else if (!primed) begin
      a_f   <= a_s;
      a_cnt <= '0;
    end else if (a_s == a_f) begin
      a_cnt <= '0;
    end else if (a_cnt == FILT_MAX) begin
      a_f   <= a_s;
      a_cnt <= '0;
    end else begin
      a_cnt <= a_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_f   <= 1'b0;
      b_cnt <= '0;
    end else if (!primed) begin
      b_f   <= b_s;
      b_cnt <= '0;
    end else if (b_s == b_f) begin
      b_cnt <= '0;
    end else if (b_cnt == FILT_MAX) begin
      b_f   <= b_s;
      b_cnt <= '0;
    end else begin
      b_cnt <= b_cnt + 4'd1;
    end
  end

  assign cur = {a_f, b_f};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S00;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state_t'(cur);
  end

  // Anything that is neither one step forward nor one step back has both bits flipped.
  always_comb begin
    en_nxt  = 1'b0;
    dir_nxt = dir;
    err_set = 1'b0;
    if (primed && (cur != state)) begin
      if (state_t'(cur) == up_of(state)) begin
        en_nxt  = 1'b1;
        dir_nxt = 1'b1;
      end else if (state == up_of(state_t'(cur))) begin
        en_nxt  = 1'b1;
        dir_nxt = 1'b0;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en  <= 1'b0;
      dir <= 1'b0;
      err <= 1'b0;
    end else begin
      en  <= en_nxt;
      dir <= dir_nxt;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with FILT_CYC=4 and a downstream 8-bit counter model.
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic rst, a_in, b_in, err_clr;
  logic en, dir, err, a_f, b_f;

  int total = 0;
  int bad = 0;
  int ecount = 0;
  logic [7:0] cnt = 8'd0;
  logic [7:0] base;
  int ebase;

  quad_step_decoder #(.FILT_CYC(4)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
    .en(en), .dir(dir), .err(err), .a_f(a_f), .b_f(b_f)
  );

  always #5 clk = ~clk;

  // Counter consuming en/dir, sampled mid-cycle.
  always @(negedge clk) begin
    if (en === 1'b1) begin
      ecount <= ecount + 1;
      cnt    <= (dir === 1'b1) ? cnt + 8'd1 : cnt - 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change before edge k: filtered level after k+5, en only in the cycle after k+6.
  task automatic do_step(input logic a, input logic b, input logic d, input string tag);
    a_in = a;
    b_in = b;
    repeat (6) tick();
    chk({tag, "_filt"}, {6'b0, a_f, b_f}, {6'b0, a, b});
    chkb({tag, "_pre"}, en, 1'b0);
    tick();
    chkb({tag, "_en"}, en, 1'b1);
    chkb({tag, "_dir"}, dir, d);
    tick();
    chkb({tag, "_one"}, en, 1'b0);
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1; a_in = 1'b0; b_in = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("reset_out", {3'b0, en, dir, err, a_f, b_f}, 8'd0);
    rst = 1'b0;
    repeat (12) tick();
    chk("primed_idle", {5'b0, en, err, a_f}, 8'd0);
    chk("cnt_start", cnt, 8'd0);

    do_step(1'b1, 1'b0, 1'b1, "up1");
    do_step(1'b1, 1'b1, 1'b1, "up2");
    do_step(1'b0, 1'b1, 1'b1, "up3");
    do_step(1'b0, 1'b0, 1'b1, "up4");
    chk("cnt_up", cnt, 8'd4);

    base = cnt;
    do_step(1'b0, 1'b1, 1'b0, "dn1");
    do_step(1'b1, 1'b1, 1'b0, "dn2");
    do_step(1'b1, 1'b0, 1'b0, "dn3");
    do_step(1'b0, 1'b0, 1'b0, "dn4");
    chk("cnt_down", cnt - base, 8'd252);

    ebase = ecount;
    a_in = 1'b1;
    repeat (3) tick();
    a_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chkb("glitch_af", a_f, 1'b0);
      chkb("glitch_en", en, 1'b0);
    end
    chk("glitch_pulses", 8'(ecount - ebase), 8'd0);
    chkb("glitch_err", err, 1'b0);

    ebase = ecount;
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (6) tick();
    chkb("ill_err_pre", err, 1'b0);
    chk("ill_filt", {6'b0, a_f, b_f}, 8'd3);
    tick();
    chkb("ill_err", err, 1'b1);
    chkb("ill_en", en, 1'b0);
    chkb("ill_dir", dir, 1'b0);
    repeat (3) tick();
    chk("ill_pulses", 8'(ecount - ebase), 8'd0);
    do_step(1'b0, 1'b1, 1'b1, "ill_next");

    a_in = 1'b1;
    b_in = 1'b0;
    repeat (6) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chkb("clr_same_err", err, 1'b1);
    chkb("clr_same_en", en, 1'b0);
    chkb("clr_same_dir", dir, 1'b1);
    tick();
    chkb("clr_sticky", err, 1'b1);
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chkb("clr_alone", err, 1'b0);
    repeat (2) tick();

    do_step(1'b1, 1'b1, 1'b1, "pre_rst");
    rst = 1'b1;
    #2;
    chk("rst_async", {3'b0, en, dir, err, a_f, b_f}, 8'd0);
    repeat (3) tick();
    chk("rst_hold", {3'b0, en, dir, err, a_f, b_f}, 8'd0);
    rst = 1'b0;
    ebase = ecount;
    for (int i = 0; i < 10; i++) begin
      tick();
      chkb("rel_en", en, 1'b0);
      chkb("rel_err", err, 1'b0);
    end
    chk("rel_filt", {6'b0, a_f, b_f}, 8'd3);
    chk("rel_pulses", 8'(ecount - ebase), 8'd0);
    do_step(1'b0, 1'b1, 1'b1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
